// File: rtl/div_seq.sv
// Purpose: reciprocal / reciprocal-square-root sequencer: normalise, table lookup, interpolate, denormalise.
// Latency: done in cycle 4 + NORM cycles + (TBL_LAT-1) after the start edge; zero operand done in cycle 3.
// Backpressure: none queued; start is ignored while busy (including the done cycle), kill aborts to IDLE.
module div_seq #(
    parameter int COARSE  = 4,
    parameter int TBL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rsq,
    input  logic        kill,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        tbl_rd,
    output logic [6:0]  tbl_addr,
    output logic [3:0]  interp_frac,
    input  logic [15:0] interp_sum
);

    // Wait counter only needs to reach TBL_LAT-2; keep at least one bit.
    localparam int WCW = (TBL_LAT > 2) ? $clog2(TBL_LAT - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_LOOK,
        S_WAIT,
        S_INTERP,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mag_q, mag_d;
    logic [4:0]      sh_q, sh_d;
    logic            neg_q, neg_d;
    logic            rsq_q, rsq_d;
    logic            zero_q, zero_d;
    logic [15:0]     s_q, s_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [31:0]     result_q, result_d;
    logic            tbl_rd_q, tbl_rd_d;
    logic [6:0]      tbl_addr_q, tbl_addr_d;
    logic [3:0]      frac_q, frac_d;

    logic [31:0]     q_full;
    logic [4:0]      d_amt;
    logic [31:0]     m_val;
    logic [31:0]     out_res;

    // Denormalise the captured mantissa and apply sign / saturation.
    always_comb begin
        q_full  = {1'b1, s_q, 15'b0};
        d_amt   = rsq_q ? ((5'd31 - sh_q) >> 1) : (5'd31 - sh_q);
        m_val   = q_full >> d_amt;
        out_res = m_val;
        if (zero_q) begin
            out_res = 32'h7FFF_FFFF;
        end else if (!neg_q && (m_val > 32'h7FFF_FFFF)) begin
            out_res = 32'h7FFF_FFFF;
        end else if (neg_q && (m_val > 32'h8000_0000)) begin
            out_res = 32'h8000_0000;
        end else if (neg_q) begin
            out_res = -m_val;
        end
    end

    // Next-state and datapath updates; kill overrides every non-IDLE transition.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        sh_d       = sh_q;
        neg_d      = neg_q;
        rsq_d      = rsq_q;
        zero_d     = zero_q;
        s_d        = s_q;
        wait_d     = wait_q;
        result_d   = result_q;
        tbl_addr_d = tbl_addr_q;
        frac_d     = frac_q;
        done_d     = 1'b0;
        tbl_rd_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high in the done cycle, which blocks a back-to-back start.
                if (start && !busy_q && !kill) begin
                    neg_d   = din[31];
                    mag_d   = din[31] ? -din : din;
                    sh_d    = 5'd0;
                    rsq_d   = rsq;
                    zero_d  = 1'b0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q == 32'd0) begin
                    zero_d  = 1'b1;
                    state_d = S_OUT;
                end else if (mag_q[31]) begin
                    tbl_rd_d = 1'b1;
                    if (rsq_q) begin
                        tbl_addr_d = {1'b1, sh_q[0], mag_q[30:26]};
                        frac_d     = mag_q[25:22];
                    end else begin
                        tbl_addr_d = {1'b0, mag_q[30:25]};
                        frac_d     = mag_q[24:21];
                    end
                    state_d = S_LOOK;
                end else if (mag_q[31 -: COARSE] == '0) begin
                    mag_d = mag_q << COARSE;
                    sh_d  = sh_q + 5'(COARSE);
                end else begin
                    mag_d = mag_q << 1;
                    sh_d  = sh_q + 5'd1;
                end
            end
            S_LOOK: begin
                wait_d  = '0;
                state_d = (TBL_LAT == 1) ? S_INTERP : S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WCW'(TBL_LAT - 2)) begin
                    state_d = S_INTERP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_INTERP: begin
                s_d     = interp_sum;
                state_d = S_OUT;
            end
            S_OUT: begin
                result_d = out_res;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            tbl_rd_d = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE) || done_d;
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mag_q      <= 32'd0;
            sh_q       <= 5'd0;
            neg_q      <= 1'b0;
            rsq_q      <= 1'b0;
            zero_q     <= 1'b0;
            s_q        <= 16'd0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            tbl_rd_q   <= 1'b0;
            tbl_addr_q <= 7'd0;
            frac_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            sh_q       <= sh_d;
            neg_q      <= neg_d;
            rsq_q      <= rsq_d;
            zero_q     <= zero_d;
            s_q        <= s_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            tbl_rd_q   <= tbl_rd_d;
            tbl_addr_q <= tbl_addr_d;
            frac_q     <= frac_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign tbl_rd      = tbl_rd_q;
    assign tbl_addr    = tbl_addr_q;
    assign interp_frac = frac_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed operations with a reference model feeding an expected-result queue.
// Table ROM plus interpolator is modelled as sum = pnt + slp*frac, one cycle after tbl_rd.
// Checks reset state, results, latency, table address/fraction, start-while-busy, kill and async reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rsq;
    logic        kill;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        tbl_rd;
    logic [6:0]  tbl_addr;
    logic [3:0]  interp_frac;
    logic [15:0] interp_sum;

    logic [15:0] tb_pnt;
    logic [15:0] tb_slp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic [6:0]  addr;
        logic [3:0]  frac;
        bit          zero;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res;

    div_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rsq         (rsq),
        .kill        (kill),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .tbl_rd      (tbl_rd),
        .tbl_addr    (tbl_addr),
        .interp_frac (interp_frac),
        .interp_sum  (interp_sum)
    );

    always #5 clk = ~clk;

    // Table + interpolator stand-in: result available the cycle after the read strobe.
    always @(posedge clk) begin
        if (tbl_rd) interp_sum <= tb_pnt + tb_slp * {12'd0, interp_frac};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic r,
                                   input logic [15:0] pnt, input logic [15:0] slp);
        exp_t        e;
        logic        neg;
        logic [31:0] mag, nm, q, m;
        logic [15:0] s;
        logic [4:0]  sh, d;
        int          lz;
        e   = '{res: 32'd0, cyc: 0, addr: 7'd0, frac: 4'd0, zero: 1'b0};
        neg = a[31];
        mag = neg ? (~a + 32'd1) : a;
        if (mag == 32'd0) begin
            e.zero = 1'b1;
            e.res  = 32'h7FFF_FFFF;
            e.cyc  = 3;
            return e;
        end
        lz = 0;
        while (!mag[31 - lz]) lz++;
        nm = mag << lz;
        sh = 5'(lz);
        if (r) begin
            e.addr = {1'b1, sh[0], nm[30:26]};
            e.frac = nm[25:22];
        end else begin
            e.addr = {1'b0, nm[30:25]};
            e.frac = nm[24:21];
        end
        s = pnt + slp * {12'd0, e.frac};
        q = {1'b1, s, 15'b0};
        d = r ? 5'((31 - lz) / 2) : 5'(31 - lz);
        m = q >> d;
        if (!neg && m > 32'h7FFF_FFFF)      e.res = 32'h7FFF_FFFF;
        else if (neg && m > 32'h8000_0000)  e.res = 32'h8000_0000;
        else                                e.res = neg ? (~m + 32'd1) : m;
        e.cyc = 4 + 1 + lz / 4 + lz % 4;
        return e;
    endfunction

    // One complete operation; poke adds a start while busy and a start in the done cycle.
    task automatic run_op(input logic [31:0] a, input logic r, input logic [15:0] pnt,
                          input logic [15:0] slp, input bit poke);
        exp_t        e;
        int          cyc;
        int          rd_cnt;
        bit          got;
        logic [6:0]  addr_seen;
        logic [3:0]  frac_seen;
        sb.push_back(model(a, r, pnt, slp));
        tb_pnt = pnt;
        tb_slp = slp;
        @(negedge clk);
        din   = a;
        rsq   = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~a;
        rsq   = ~r;
        cyc = 0; rd_cnt = 0; got = 1'b0; addr_seen = 7'd0; frac_seen = 4'd0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                din   = 32'h0000_0003;
            end
            if (cyc == 3) start = 1'b0;
            if (cyc == 1) chk("busy_first_cycle", {31'd0, busy}, 32'd1);
            if (tbl_rd) begin
                rd_cnt++;
                addr_seen = tbl_addr;
                frac_seen = interp_frac;
            end
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("result", result, e.res);
            chk("busy_in_done", {31'd0, busy}, 32'd1);
            last_res = e.res;
        end
        chk("tbl_rd_count", 32'(rd_cnt), e.zero ? 32'd0 : 32'd1);
        if (!e.zero) begin
            chk("tbl_addr", {25'd0, addr_seen}, {25'd0, e.addr});
            chk("interp_frac", {28'd0, frac_seen}, {28'd0, e.frac});
        end
        if (poke) begin
            start = 1'b1;
            din   = 32'h0000_0005;
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
        chk("idle_after_done_done", {31'd0, done}, 32'd0);
        chk("result_held", result, last_res);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; rsq = 1'b0; kill = 1'b0; din = 32'd0;
        tb_pnt = 16'd0; tb_slp = 16'd0; last_res = 32'd0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_tbl_rd", {31'd0, tbl_rd}, 32'd0);
        chk("reset_tbl_addr", {25'd0, tbl_addr}, 32'd0);
        chk("reset_frac", {28'd0, interp_frac}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed cases, then saturation / sign corners and a few mixed operands.
        run_op(32'h4000_0000, 1'b0, 16'h8000, 16'h0000, 1'b0);
        run_op(32'h0000_0000, 1'b0, 16'h1234, 16'h0000, 1'b0);
        run_op(32'hFFFF_FFFF, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_op(32'h0100_0000, 1'b1, 16'h0000, 16'h0000, 1'b0);
        run_op(32'h0000_0001, 1'b0, 16'h1000, 16'h0000, 1'b0);
        run_op(32'h8000_0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_op(32'h0001_2345, 1'b0, 16'h1234, 16'h0101, 1'b1);
        run_op(32'hFFFF_0000, 1'b1, 16'hABCD, 16'h0003, 1'b0);
        run_op(32'h0000_0000, 1'b1, 16'h0000, 16'h0000, 1'b0);
        run_op(32'h7FFF_FFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op($urandom >> $urandom_range(0, 31), 1'($urandom), 16'($urandom),
                   16'($urandom_range(0, 255)), 1'b0);
        end

        // Kill during NORM: no done, result kept, next op normal.
        @(negedge clk);
        din = 32'h0000_0001; rsq = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("kill_no_done", 32'(ndone), 32'd0);
        chk("kill_result_kept", result, last_res);
        run_op(32'h0000_0F00, 1'b0, 16'h4321, 16'h0000, 1'b0);

        // Kill and start together in IDLE: start dropped.
        @(negedge clk);
        din = 32'h4000_0000; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("kill_start_busy2", {31'd0, busy}, 32'd0);

        // Async reset during INTERP (cycle 4 for this operand).
        din = 32'h4000_0000; rsq = 1'b0; start = 1'b1; tb_pnt = 16'h8000; tb_slp = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_tbl_rd", {31'd0, tbl_rd}, 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_op(32'h4000_0000, 1'b0, 16'h8000, 16'h0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
